stk_pipe_wrbk: RTL and testbench

- Writeback/response stage at the tail of the stack pipe; the return end of the admission stage's command/ack protocol.
- Captures the final microcode for each completed command and presents a per-engine response (opcode, status, pop data) to the owning engine.
- Once the engine consumes the response, issues the writeback clear (`o_wrbk_uc_vld_r` / `o_wrbk_uc_engid_r`), which releases that engine's bit in the admission stage's active set.

---
 rtl/stk_pipe_wrbk_pkg.sv | 34 +++
 rtl/stk_pipe_wrbk_slot.sv | 49 ++++
 rtl/stk_pipe_wrbk.sv | 104 ++++++++++
 tb/tb_stk_pipe_wrbk.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stk_pipe_wrbk_pkg.sv
// Shared configuration and stack-pipe types used by the writeback/response stage.
package cfg_pkg;
    localparam int unsigned ENGS_N = 4;
endpackage

package stk_pkg;
    localparam int unsigned ENGID_W   = 3;
    localparam int unsigned OPCODE_W  = 2;
    localparam int unsigned RSP_DAT_W = 128;

    typedef logic [ENGID_W-1:0] engid_t;

    typedef enum logic [OPCODE_W-1:0] {
        OPCODE_INV  = 2'd0,
        OPCODE_PUSH = 2'd1,
        OPCODE_POP  = 2'd2
    } opcode_t;

    typedef struct packed {
        opcode_t                opcode;
        logic                   err;
        logic [RSP_DAT_W-1:0]   dat;
    } wrbk_rsp_t;

    // Only a successful POP carries data back; everything else reports zero.
    function automatic wrbk_rsp_t mk_rsp(input opcode_t opcode, input logic err,
                                         input logic [RSP_DAT_W-1:0] dat);
        wrbk_rsp_t r;
        r.opcode = opcode;
        r.err    = err;
        r.dat    = (opcode == OPCODE_POP && !err) ? dat : '0;
        return r;
    endfunction
endpackage

// File: rtl/stk_pipe_wrbk_slot.sv
// One engine's response slot: holds a completed command until the engine acks it.
module stk_pipe_wrbk_slot
    import stk_pkg::*;
(
    input  logic      clk,
    input  logic      arst_n,
    input  logic      wr,
    input  wrbk_rsp_t wr_rsp,
    input  logic      ack,
    output logic      rsp_vld,
    output wrbk_rsp_t rsp
);
    typedef enum logic {IDLE = 1'b0, FULL = 1'b1} slot_state_t;

    slot_state_t state;
    slot_state_t state_nxt;
    wrbk_rsp_t   store;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr)  state_nxt = FULL;
            FULL:    if (ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A write arriving while FULL is dropped; the held response stays intact.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            store <= '0;
        end else if (state == IDLE && wr) begin
            store <= wr_rsp;
        end
    end

    always_comb begin
        rsp_vld = (state == FULL);
        rsp     = (state == FULL) ? store : '0;
    end
endmodule

// File: rtl/stk_pipe_wrbk.sv
// Writeback/response stage: per-engine response slots plus round-robin active-set clears.
module stk_pipe_wrbk
    import stk_pkg::*;
#(
    parameter int unsigned ENGS_N = cfg_pkg::ENGS_N,
    parameter int unsigned DAT_W  = 128
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       i_wr_vld,
    input  logic [ENGID_W-1:0]         i_wr_engid,
    input  logic [OPCODE_W-1:0]        i_wr_opcode,
    input  logic                       i_wr_err,
    input  logic [DAT_W-1:0]           i_wr_dat,
    output logic [ENGS_N-1:0]          o_rsp_vld,
    output logic [ENGS_N*OPCODE_W-1:0] o_rsp_opcode,
    output logic [ENGS_N-1:0]          o_rsp_err,
    output logic [ENGS_N*DAT_W-1:0]    o_rsp_dat,
    input  logic [ENGS_N-1:0]          i_rsp_ack,
    output logic                       o_wrbk_uc_vld_r,
    output logic [ENGID_W-1:0]         o_wrbk_uc_engid_r,
    output logic                       o_proto_err_r
);
    localparam int unsigned PTR_W = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;

    logic              in_range;
    logic [ENGS_N-1:0] wr_sel;
    logic [ENGS_N-1:0] full;
    logic [ENGS_N-1:0] ack_fire;
    logic [ENGS_N-1:0] pending;
    logic [ENGS_N-1:0] gnt;
    logic              gnt_any;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W-1:0]  cand;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  rr_nxt;
    logic              viol;
    wrbk_rsp_t         wr_rsp;
    wrbk_rsp_t         slot_rsp [ENGS_N];

    always_comb begin
        in_range = (32'(i_wr_engid) < ENGS_N);
        wr_rsp   = mk_rsp(opcode_t'(i_wr_opcode), i_wr_err, RSP_DAT_W'(i_wr_dat));
        wr_sel   = '0;
        for (int unsigned e = 0; e < ENGS_N; e++) begin
            wr_sel[e] = i_wr_vld && in_range && (i_wr_engid == ENGID_W'(e));
        end
    end

    for (genvar e = 0; e < ENGS_N; e++) begin : g_slot
        stk_pipe_wrbk_slot u_slot (
            .clk    (clk),
            .arst_n (arst_n),
            .wr     (wr_sel[e]),
            .wr_rsp (wr_rsp),
            .ack    (i_rsp_ack[e]),
            .rsp_vld(full[e]),
            .rsp    (slot_rsp[e])
        );
        assign o_rsp_opcode[e*OPCODE_W +: OPCODE_W] = slot_rsp[e].opcode;
        assign o_rsp_err[e]                         = slot_rsp[e].err;
        assign o_rsp_dat[e*DAT_W +: DAT_W]          = DAT_W'(slot_rsp[e].dat);
    end

    assign o_rsp_vld = full;
    assign ack_fire  = full & i_rsp_ack;

    // Search pending starting at the rr pointer; the first hit wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < ENGS_N; k++) begin
            cand = PTR_W'((32'(rr_ptr) + k) % ENGS_N);
            if (!gnt_any && pending[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt    = gnt_any ? (ENGS_N'(1) << gnt_idx) : '0;
        rr_nxt = (32'(gnt_idx) == ENGS_N - 1) ? '0 : gnt_idx + 1'b1;
        viol   = i_wr_vld && (!in_range || (|(wr_sel & (full | pending))));
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pending           <= '0;
            rr_ptr            <= '0;
            o_wrbk_uc_vld_r   <= 1'b0;
            o_wrbk_uc_engid_r <= '0;
            o_proto_err_r     <= 1'b0;
        end else begin
            pending           <= (pending & ~gnt) | ack_fire;
            o_wrbk_uc_vld_r   <= gnt_any;
            o_wrbk_uc_engid_r <= gnt_any ? ENGID_W'(gnt_idx) : '0;
            if (gnt_any) begin
                rr_ptr <= rr_nxt;
            end
            if (viol) begin
                o_proto_err_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stk_pipe_wrbk.sv
// Bench for stk_pipe_wrbk: directed scenarios plus random traffic against a behavioural model.
module tb_stk_pipe_wrbk;
    import stk_pkg::*;

    localparam int N  = 4;
    localparam int DW = 128;
    localparam int OW = OPCODE_W;
    localparam int IW = ENGID_W;

    logic            clk = 1'b0;
    logic            arst_n = 1'b1;
    logic            wr_vld;
    logic [IW-1:0]   wr_engid;
    logic [OW-1:0]   wr_opcode;
    logic            wr_err;
    logic [DW-1:0]   wr_dat;
    logic [N-1:0]    rsp_vld;
    logic [N*OW-1:0] rsp_opcode;
    logic [N-1:0]    rsp_err;
    logic [N*DW-1:0] rsp_dat;
    logic [N-1:0]    rsp_ack;
    logic            wb_vld;
    logic [IW-1:0]   wb_id;
    logic            proto_err;

    always #5 clk = ~clk;

    stk_pipe_wrbk #(.ENGS_N(N), .DAT_W(DW)) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .i_wr_vld         (wr_vld),
        .i_wr_engid       (wr_engid),
        .i_wr_opcode      (wr_opcode),
        .i_wr_err         (wr_err),
        .i_wr_dat         (wr_dat),
        .o_rsp_vld        (rsp_vld),
        .o_rsp_opcode     (rsp_opcode),
        .o_rsp_err        (rsp_err),
        .o_rsp_dat        (rsp_dat),
        .i_rsp_ack        (rsp_ack),
        .o_wrbk_uc_vld_r  (wb_vld),
        .o_wrbk_uc_engid_r(wb_id),
        .o_proto_err_r    (proto_err)
    );

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: which engines hold a response, which owe a clear, and the rr pointer.
    bit            m_full [N];
    logic [OW-1:0] m_op   [N];
    bit            m_err  [N];
    logic [DW-1:0] m_dat  [N];
    bit            m_pend [N];
    int            m_ptr;
    bit            m_wbv;
    int            m_wbid;
    bit            m_perr;
    int            wb_seen;
    logic [N-1:0]  wb_mask;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < N; e++) begin
            m_full[e] = 0; m_op[e] = '0; m_err[e] = 0; m_dat[e] = '0; m_pend[e] = 0;
        end
        m_ptr = 0; m_wbv = 0; m_wbid = 0; m_perr = 0;
    endtask

    task automatic model_edge();
        bit fire  [N];
        bit pend0 [N];
        int id;
        for (int e = 0; e < N; e++) begin
            fire[e]  = m_full[e] && rsp_ack[e];
            pend0[e] = m_pend[e];
        end
        m_wbv = 0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (!m_wbv && pend0[c]) begin
                m_wbv = 1;
                m_wbid = c;
            end
        end
        if (m_wbv) begin
            m_pend[m_wbid] = 0;
            m_ptr = (m_wbid + 1) % N;
        end
        if (wr_vld) begin
            id = int'(wr_engid);
            if (id >= N || m_full[id]) begin
                m_perr = 1;
            end else begin
                if (pend0[id]) m_perr = 1;
                m_full[id] = 1;
                m_op[id]   = wr_opcode;
                m_err[id]  = wr_err;
                m_dat[id]  = (wr_opcode == OPCODE_POP && !wr_err) ? wr_dat : '0;
            end
        end
        for (int e = 0; e < N; e++) begin
            if (fire[e]) begin
                m_full[e] = 0;
                m_pend[e] = 1;
            end
        end
    endtask

    task automatic check_all();
        logic [N-1:0] ev;
        for (int e = 0; e < N; e++) ev[e] = m_full[e];
        check("rsp_vld", DW'(rsp_vld), DW'(ev));
        for (int e = 0; e < N; e++) begin
            if (m_full[e]) begin
                check($sformatf("rsp_opcode[%0d]", e), DW'(rsp_opcode[e*OW +: OW]), DW'(m_op[e]));
                check($sformatf("rsp_err[%0d]", e), DW'(rsp_err[e]), DW'(m_err[e]));
                check($sformatf("rsp_dat[%0d]", e), rsp_dat[e*DW +: DW], m_dat[e]);
            end
        end
        check("wb_vld", DW'(wb_vld), DW'(m_wbv));
        if (m_wbv) check("wb_engid", DW'(wb_id), DW'(m_wbid));
        check("proto_err", DW'(proto_err), DW'(m_perr));
        if (wb_vld) begin
            wb_seen++;
            if (int'(wb_id) < N) wb_mask[wb_id[1:0]] = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input int e, input logic [OW-1:0] op, input bit err, input logic [DW-1:0] d);
        wr_vld = 1'b1; wr_engid = IW'(e); wr_opcode = op; wr_err = err; wr_dat = d;
        step();
        wr_vld = 1'b0;
    endtask

    task automatic ack_once(input logic [N-1:0] a);
        rsp_ack = a;
        step();
        rsp_ack = '0;
    endtask

    initial begin
        int guard;
        bit drained;
        int free_q[$];
        wr_vld = 0; wr_engid = '0; wr_opcode = '0; wr_err = 0; wr_dat = '0; rsp_ack = '0;
        wb_seen = 0; wb_mask = '0;
        model_reset();

        #2 arst_n = 1'b0;
        #1;
        check("rst_rsp_vld", DW'(rsp_vld), '0);
        check("rst_rsp_err", DW'(rsp_err), '0);
        check("rst_rsp_opcode", DW'(rsp_opcode), '0);
        check("rst_rsp_dat0", rsp_dat[DW-1:0], '0);
        check("rst_wb_vld", DW'(wb_vld), '0);
        check("rst_wb_engid", DW'(wb_id), '0);
        check("rst_proto_err", DW'(proto_err), '0);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;

        // Successful POP on engine 2, consumed after a few cycles
        send(2, OPCODE_POP, 0, DW'(32'hDEAD_BEEF));
        check("pop_dat", rsp_dat[2*DW +: DW], DW'(32'hDEAD_BEEF));
        repeat (3) step();
        ack_once(4'b0100);
        repeat (3) step();

        // Failed PUSH on engine 1 held un-acked
        send(1, OPCODE_PUSH, 1, DW'(8'h55));
        wb_seen = 0;
        repeat (20) step();
        check("push_hold_no_clear", DW'(wb_seen), '0);
        check("push_dat_zero", rsp_dat[1*DW +: DW], '0);
        ack_once(4'b0010);
        repeat (3) step();

        // Simultaneous acks on 0, 1, 3, twice
        repeat (2) begin
            send(0, OPCODE_POP, 0, {$urandom, $urandom, $urandom, $urandom});
            send(1, OPCODE_INV, 0, {$urandom, $urandom, $urandom, $urandom});
            send(3, OPCODE_POP, 0, {$urandom, $urandom, $urandom, $urandom});
            step();
            wb_seen = 0;
            ack_once(4'b1011);
            repeat (5) step();
            check("multi_ack_clears", DW'(wb_seen), DW'(3));
        end

        // Write to a FULL slot is dropped and flagged
        send(3, OPCODE_POP, 0, DW'(1));
        send(3, OPCODE_POP, 0, DW'(32'hFFFF));
        check("collide_keep_dat", rsp_dat[3*DW +: DW], DW'(1));
        check("collide_err", DW'(proto_err), DW'(1));
        step();
        ack_once(4'b1000);
        repeat (3) step();

        // Back-to-back completions with random ack delays
        wb_seen = 0; wb_mask = '0;
        for (int e = 0; e < N; e++) send(e, OPCODE_POP, 0, {$urandom, $urandom, $urandom, $urandom});
        drained = 0;
        guard = 0;
        while (!drained && guard < 200) begin
            rsp_ack = N'($urandom & $urandom);
            step();
            guard++;
            drained = !m_wbv;
            for (int e = 0; e < N; e++) if (m_full[e] || m_pend[e]) drained = 0;
        end
        rsp_ack = '0;
        check("b2b_drained", DW'(drained), DW'(1));
        check("b2b_clear_count", DW'(wb_seen), DW'(4));
        check("b2b_clear_ids", DW'(wb_mask), DW'(4'hF));

        // Random traffic, mostly legal, occasionally violating
        for (int i = 0; i < 1500; i++) begin
            wr_vld = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0) begin
                wr_engid = IW'($urandom_range(0, (1 << IW) - 1));
            end else begin
                free_q.delete();
                for (int e = 0; e < N; e++) if (!m_full[e] && !m_pend[e]) free_q.push_back(e);
                if (free_q.size() == 0) wr_vld = 0;
                else wr_engid = IW'(free_q[$urandom_range(0, free_q.size() - 1)]);
            end
            wr_opcode = OW'($urandom_range(0, 2));
            wr_err    = ($urandom_range(0, 3) == 0);
            wr_dat    = {$urandom, $urandom, $urandom, $urandom};
            rsp_ack   = N'($urandom & $urandom);
            step();
        end
        wr_vld = 0;
        rsp_ack = '1;
        repeat (10) step();
        rsp_ack = '0;

        // Reset with two FULL slots and one pending clear
        send(0, OPCODE_POP, 0, DW'(7));
        send(1, OPCODE_PUSH, 0, DW'(8));
        send(2, OPCODE_POP, 0, DW'(9));
        ack_once(4'b0100);
        arst_n = 1'b0;
        #1;
        check("midrst_rsp_vld", DW'(rsp_vld), '0);
        check("midrst_wb_vld", DW'(wb_vld), '0);
        check("midrst_proto_err", DW'(proto_err), '0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        wb_seen = 0;
        repeat (10) step();
        check("post_rst_no_clear", DW'(wb_seen), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
